// File: rtl/seg_pkg.sv
// Shared definitions for the eight-digit seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS    = 8;
    localparam int GUARD_CYC_DEF = 2000;
    localparam int STEP_CYC_DEF  = 12250;

    typedef enum logic [1:0] {
        GUARD,
        ON,
        OFF
    } phase_t;

    // Digit i is dark when masked, or when leading-zero suppression is on and
    // nibbles i..7 are all zero; digit 0 always shows so "0" stays visible.
    function automatic logic [NUM_DIGITS-1:0] blank_vec(
        input logic [4*NUM_DIGITS-1:0] data,
        input logic [NUM_DIGITS-1:0]   mask,
        input logic                    blank_lz
    );
        logic                  lz;
        logic [NUM_DIGITS-1:0] b;
        lz = 1'b1;
        b  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz   = lz & (data[4*i +: 4] == 4'h0);
            b[i] = ~mask[i] | (blank_lz & lz & (i != 0));
        end
        return b;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to seven-segment pattern, y = {g,f,e,d,c,b,a}, active-low segments.
module seg_decoder (
    input  logic [3:0] x,
    output logic [6:0] y
);

    always_comb begin
        y = 7'h7F;
        case (x)
            4'h0: y = 7'h40;
            4'h1: y = 7'h79;
            4'h2: y = 7'h24;
            4'h3: y = 7'h30;
            4'h4: y = 7'h19;
            4'h5: y = 7'h12;
            4'h6: y = 7'h02;
            4'h7: y = 7'h78;
            4'h8: y = 7'h00;
            4'h9: y = 7'h10;
            4'hA: y = 7'h08;
            4'hB: y = 7'h03;
            4'hC: y = 7'h46;
            4'hD: y = 7'h21;
            4'hE: y = 7'h06;
            4'hF: y = 7'h0E;
            default: y = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit display scanner with ghost guard, PWM brightness and
// frame-synchronous shadow update.
//
//   state | meaning
//   GUARD | start of slot, all anodes off while segment lines settle
//   ON    | current digit's anode driven (unless blanked)
//   OFF   | remainder of slot, anodes off (empty at full brightness)
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int GUARD_CYC = GUARD_CYC_DEF,
    parameter int STEP_CYC  = STEP_CYC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  upd_mask,
    input  logic [2:0]  upd_duty,
    input  logic        upd_blank_lz,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [6:0]  hex,
    output logic        DP,
    output logic [7:0]  AN,
    output logic        frame_tick
);

    localparam int             SLOT_CYC = GUARD_CYC + NUM_DIGITS * STEP_CYC;
    localparam int             KW       = $clog2(SLOT_CYC);
    localparam logic [KW-1:0]  K_LAST   = KW'(SLOT_CYC - 1);
    localparam logic [2:0]     D_LAST   = 3'(NUM_DIGITS - 1);

    logic          run_q;
    logic [2:0]    d;
    logic [KW-1:0] k;
    phase_t        phase;

    logic [31:0]   data_q;
    logic [7:0]    dp_q;
    logic [7:0]    mask_q;
    logic [2:0]    duty_q;
    logic          blz_q;

    logic          accept;
    logic [31:0]   data_n;
    logic [7:0]    dp_n;
    logic [7:0]    mask_n;
    logic [2:0]    duty_n;
    logic          blz_n;
    logic [2:0]    d_nxt;
    logic [KW-1:0] k_nxt;
    logic [31:0]   on_end;
    phase_t        phase_n;
    logic [7:0]    blank_n;
    logic [3:0]    nib_n;
    logic [6:0]    seg_y;

    // Settings seen by the next cycle: freshly accepted fields win on the
    // transfer edge so slot 0 of the new frame already uses them.
    assign accept = upd_ready & upd_valid;
    assign data_n = accept ? upd_data     : data_q;
    assign dp_n   = accept ? upd_dp       : dp_q;
    assign mask_n = accept ? upd_mask     : mask_q;
    assign duty_n = accept ? upd_duty     : duty_q;
    assign blz_n  = accept ? upd_blank_lz : blz_q;

    assign blank_n = blank_vec(data_n, mask_n, blz_n);
    assign on_end  = 32'(GUARD_CYC) + (32'(duty_n) + 32'd1) * 32'(STEP_CYC);
    assign nib_n   = resetn ? data_n[{d_nxt, 2'b00} +: 4] : 4'h0;

    // The first edge after reset release parks at (0,0) so that cycle carries frame_tick.
    always_comb begin
        d_nxt = d;
        k_nxt = k;
        if (!run_q) begin
            d_nxt = '0;
            k_nxt = '0;
        end else if (k == K_LAST) begin
            d_nxt = d + 3'd1;
            k_nxt = '0;
        end else begin
            k_nxt = k + KW'(1);
        end
    end

    always_comb begin
        phase_n = phase;
        if (k_nxt == '0) begin
            phase_n = (GUARD_CYC == 0) ? ON : GUARD;
        end else begin
            case (phase)
                GUARD:   if (32'(k_nxt) == 32'(GUARD_CYC)) phase_n = ON;
                ON:      if (32'(k_nxt) == on_end)         phase_n = OFF;
                default: phase_n = phase;
            endcase
        end
    end

    seg_decoder u_dec (
        .x (nib_n),
        .y (seg_y)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q      <= 1'b0;
            d          <= '0;
            k          <= '0;
            phase      <= GUARD;
            data_q     <= '0;
            dp_q       <= '0;
            mask_q     <= 8'hFF;
            duty_q     <= 3'd7;
            blz_q      <= 1'b0;
            AN         <= 8'hFF;
            DP         <= 1'b1;
            hex        <= seg_y;
            upd_ready  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            d          <= d_nxt;
            k          <= k_nxt;
            phase      <= phase_n;
            data_q     <= data_n;
            dp_q       <= dp_n;
            mask_q     <= mask_n;
            duty_q     <= duty_n;
            blz_q      <= blz_n;
            AN         <= (phase_n == ON && !blank_n[d_nxt]) ? ~(8'h01 << d_nxt) : 8'hFF;
            DP         <= ~dp_n[d_nxt];
            hex        <= seg_y;
            upd_ready  <= (d_nxt == D_LAST) && (k_nxt == K_LAST);
            frame_tick <= (d_nxt == 3'd0) && (k_nxt == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a 10-cycle slot (guard 2, step 1).
module tb_seg_scan_ctrl;

    localparam int G    = 2;
    localparam int S    = 1;
    localparam int SLOT = G + 8 * S;

    typedef struct {
        logic [7:0] an;
        logic [6:0] hex;
        logic       dp;
        logic       tick;
        logic       rdy;
        logic       hex_vld;
        int         k;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] upd_data = '0;
    logic [7:0]  upd_dp = '0;
    logic [7:0]  upd_mask = '0;
    logic [2:0]  upd_duty = '0;
    logic        upd_blank_lz = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [6:0]  hex;
    logic        dp;
    logic [7:0]  an;
    logic        frame_tick;

    int n_chk = 0;
    int n_fail = 0;

    exp_t sb[$];

    // active-high gfedcba patterns; the display drives segments inverted
    logic [6:0] seg_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model state
    logic        mst = 1'b0;
    logic        mrdy = 1'b0;
    int          md = 0;
    int          mk = 0;
    logic [31:0] c_data = '0;
    logic [7:0]  c_dp = '0;
    logic [7:0]  c_mask = 8'hFF;
    logic [2:0]  c_duty = 3'd7;
    logic        c_blz = 1'b0;

    seg_scan_ctrl #(.GUARD_CYC(G), .STEP_CYC(S)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .upd_data     (upd_data),
        .upd_dp       (upd_dp),
        .upd_mask     (upd_mask),
        .upd_duty     (upd_duty),
        .upd_blank_lz (upd_blank_lz),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .hex          (hex),
        .DP           (dp),
        .AN           (an),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: at each edge predict what the outputs must show during the following cycle.
    initial begin
        forever begin
            exp_t e;
            int   hi;
            logic on;
            logic blank;
            logic [3:0] nib;
            @(posedge clk);
            if (!resetn) begin
                mst = 1'b0; md = 0; mk = 0; mrdy = 1'b0;
                c_data = '0; c_dp = '0; c_mask = 8'hFF; c_duty = 3'd7; c_blz = 1'b0;
                e.an = 8'hFF; e.hex = '0; e.dp = 1'b1; e.tick = 1'b0; e.rdy = 1'b0;
                e.hex_vld = 1'b0; e.k = 0;
            end else begin
                if (mrdy && upd_valid) begin
                    c_data = upd_data; c_dp = upd_dp; c_mask = upd_mask;
                    c_duty = upd_duty; c_blz = upd_blank_lz;
                end
                if (!mst) begin
                    mst = 1'b1; md = 0; mk = 0;
                end else if (mk == SLOT - 1) begin
                    mk = 0; md = (md + 1) % 8;
                end else begin
                    mk = mk + 1;
                end
                hi = 0;
                for (int i = 0; i < 8; i++)
                    if (c_data[4*i +: 4] != 4'h0) hi = i;
                blank = !c_mask[md] || (c_blz && md > hi);
                on    = (mk >= G) && (mk < G + (int'(c_duty) + 1) * S);
                nib   = c_data[4*md +: 4];
                e.an   = (on && !blank) ? ~(8'h01 << md) : 8'hFF;
                e.hex  = ~seg_ah[nib];
                e.dp   = ~c_dp[md];
                e.tick = (md == 0) && (mk == 0);
                e.rdy  = (md == 7) && (mk == SLOT - 1);
                e.hex_vld = 1'b1;
                e.k    = mk;
                mrdy   = e.rdy;
            end
            sb.push_back(e);
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("an", an, e.an);
                chk("dp", dp, e.dp);
                chk("frame_tick", frame_tick, e.tick);
                chk("upd_ready", upd_ready, e.rdy);
                if (e.hex_vld) chk("hex", hex, e.hex);
                chk("an_onehot", ($countones(~an) <= 1), 1);
                if (e.k < G) chk("an_guard", an, 8'hFF);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int d, input int k);
        int ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            step(1);
            if (md == d && mk == k) ok = 1;
        end
        chk("wait_pos", ok, 1);
    endtask

    task automatic send(input logic [31:0] data, input logic [7:0] dpv, input logic [7:0] mask,
                        input logic [2:0] duty, input logic blz);
        int ok = 0;
        upd_data = data; upd_dp = dpv; upd_mask = mask; upd_duty = duty; upd_blank_lz = blz;
        upd_valid = 1'b1;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (upd_ready) ok = 1;
        end
        chk("xfer_seen", ok, 1);
        if (ok == 1) chk("rdy_pos", md * 16 + mk, 7 * 16 + (SLOT - 1));
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok;
        step(3);
        resetn = 1'b1;
        step(2 * 8 * SLOT + 5);

        send(32'h0000_00A5, 8'h00, 8'hFF, 3'd7, 1'b1);
        step(8 * SLOT + 5);

        send(32'h8765_4321, 8'h00, 8'h0F, 3'd0, 1'b0);
        step(8 * SLOT + 5);

        wait_pos(3, 0);
        send(32'h0F1E_2D3C, 8'h80, 8'hFF, 3'd4, 1'b0);
        step(8 * SLOT + 5);

        upd_data = 32'hFFFF_FFFF; upd_dp = 8'hFF; upd_mask = 8'h01;
        upd_duty = 3'd2; upd_blank_lz = 1'b1; upd_valid = 1'b1;
        wait_pos(5, 4);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        upd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (frame_tick) ok = 1;
        end
        chk("restart_tick", ok, 1);
        step(2 * 8 * SLOT);

        for (int r = 0; r < 3; r++) begin
            send($urandom, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
            step(8 * SLOT + 7);
        end
        send(32'h0000_0000, 8'h01, 8'hFF, 3'd5, 1'b1);
        step(8 * SLOT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter GUARD_CYC, default 2000, ghost-guard cycles at the start of each digit slot with all anodes off.
REQ-002 Parameter STEP_CYC, default 12250, brightness step length; slot length SLOT_CYC = GUARD_CYC + 8*STEP_CYC (100000 cycles = 1 ms at 100 MHz).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 upd_data  input  32  eight hex nibbles; nibble i = upd_data[4i+3:4i] drives digit i.
REQ-006 upd_dp  input  8  decimal point per digit, 1 = lit.
REQ-007 upd_mask  input  8  digit enable, 1 = digit may light.
REQ-008 upd_duty  input  3  brightness; on-time = (duty+1)*STEP_CYC cycles per slot.
REQ-009 upd_blank_lz  input  1  1 = suppress leading-zero digits.
REQ-010 upd_valid  input  1  producer offers a new display frame.
REQ-011 upd_ready  output  1  controller accepts the frame this cycle.
REQ-012 hex  output  7  segment pattern of the current slot's nibble.
REQ-013 DP  output  1  decimal point, active-low.
REQ-014 AN  output  8  anode selects, active-low, at most one bit low.
REQ-015 frame_tick  output  1  one-cycle pulse at the first cycle of slot 0.

Function
REQ-016 Slot counter d (3 bits) and cycle counter k (0..SLOT_CYC-1) SHALL advance every cycle; k wraps to 0 and d increments (7 wraps to 0) at k = SLOT_CYC-1.
REQ-017 Phase FSM SHALL be GUARD (k < GUARD_CYC), ON (GUARD_CYC <= k < GUARD_CYC+(duty+1)*STEP_CYC), OFF (remainder); OFF is empty when duty = 7.
REQ-018 AN[d] SHALL be 0 only in phase ON and only if digit d is not blanked; all other AN bits are 1.
REQ-019 Digit d SHALL be blanked when mask[d] = 0, or when blank_lz = 1, d >= 1, and nibbles d..7 are all zero; digit 0 is never blanked by blank_lz.
REQ-020 hex SHALL equal the decoder output for nibble d for the whole slot; DP SHALL equal ~dp[d] for the whole slot.
REQ-021 AN, hex, DP, frame_tick and upd_ready SHALL be registered outputs whose values correspond to the current (d,k).
REQ-022 upd_ready SHALL be 1 only at d = 7, k = SLOT_CYC-1; when upd_valid is also 1, all upd_* fields load into the shadow registers on that edge.
REQ-023 Loaded fields SHALL take effect from d = 0, k = 0 of the next frame; no frame ever mixes old and new settings.
REQ-024 upd_valid without upd_ready SHALL change nothing; the producer holds upd_valid and fields stable until the transfer.
REQ-025 upd_valid asserted exactly on the ready cycle SHALL transfer with zero wait.
REQ-026 frame_tick SHALL be 1 exactly at d = 0, k = 0.

Reset
REQ-027 While resetn = 0 at a clock edge: d = 0, k = 0, AN = 8'hFF, DP = 1, upd_ready = 0, frame_tick = 0, shadow data = 0, dp = 0, mask = 8'hFF, duty = 7, blank_lz = 0.
REQ-028 The first cycle after release SHALL be d = 0, k = 0 with frame_tick = 1.
REQ-029 Reset mid-frame SHALL abort the slot at once; a pending upd_valid is not transferred during reset.

Structure
REQ-030 Shared package seg_pkg SHALL hold NUM_DIGITS = 8, the phase enum {GUARD, ON, OFF} and the default GUARD_CYC/STEP_CYC values.
REQ-031 The team's existing decoder module (x[3:0] -> y[6:0]) SHALL be the single sub-module and produce hex.
REQ-032 k width SHALL be $clog2(SLOT_CYC); the on-time product SHALL be computed without truncation.

Verification (GUARD_CYC = 2, STEP_CYC = 1, SLOT_CYC = 10, frame = 80 cycles)
REQ-033 Reset release, defaults -> AN low at k = 2..9 in each slot, walking FE, FD, ... 7F; hex = decoder(0); frame_tick every 80 cycles.
REQ-034 Transfer data = 32'h0000_00A5, blank_lz = 1, duty = 7 -> next frame: only digits 0 and 1 light, showing 5 and A; digits 2..7 keep AN = 1.
REQ-035 duty = 0, mask = 8'h0F -> AN low only at k = 2 of slots 0..3; slots 4..7 fully dark.
REQ-036 upd_valid raised mid-frame at d = 3 -> upd_ready first seen at d = 7, k = 9; transfer occurs there; new dp pattern 8'h80 gives DP = 0 only in slot 7 of the next frame.
REQ-037 resetn low for one cycle at d = 5, k = 4 while upd_valid = 1 -> AN = FF, shadow returns to defaults, no transfer; restart at d = 0, k = 0 with frame_tick = 1.
REQ-038 All runs: assertion that AN never has more than one bit low and is FF whenever k < 2.
